uart_transceiver: RTL and testbench

Parametrised full-duplex UART on a single system clock, the next generation of our separate sender/receiver pair. It generates its own baud ticks from CLK, so no divider-produced clocks are needed. It supports configurable data width, parity, stop bits and oversampling, and reports framing and parity errors. Top-level demo logic drives tx_data/tx_start and consumes rx_data/rx_valid.

---
 rtl/uart_transceiver.sv | 228 ++++++++++++++++++++++
 tb/tb_uart_transceiver.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transceiver.sv
`default_nettype none
// ============================================================================
//  Module   : uart_transceiver
//  Brief    : Full-duplex UART with internal baud tick generation, configurable
//             data width, parity, stop bits, oversampling and error reporting.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_transceiver #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx_busy,
    output logic                 TX,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);
    localparam int c_DIV_RAW  = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int c_DIV      = (c_DIV_RAW < 1) ? 1 : c_DIV_RAW;
    localparam int c_BIT_CYC  = OVERSAMPLE * c_DIV;
    localparam int c_HALF_CYC = (OVERSAMPLE / 2) * c_DIV;
    localparam int c_CW       = $clog2(c_BIT_CYC);

    localparam logic [c_CW-1:0] c_BIT_LAST  = c_CW'(c_BIT_CYC - 1);
    localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(c_HALF_CYC - 1);
    localparam logic [3:0]      c_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      c_STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic            c_ODD       = (PARITY == 1);
    localparam logic            c_HAS_PAR   = (PARITY != 0);

    localparam logic [2:0] c_TX_IDLE   = 3'd0;
    localparam logic [2:0] c_TX_START  = 3'd1;
    localparam logic [2:0] c_TX_DATA   = 3'd2;
    localparam logic [2:0] c_TX_PARITY = 3'd3;
    localparam logic [2:0] c_TX_STOP   = 3'd4;

    localparam logic [2:0] c_RX_IDLE   = 3'd0;
    localparam logic [2:0] c_RX_START  = 3'd1;
    localparam logic [2:0] c_RX_DATA   = 3'd2;
    localparam logic [2:0] c_RX_PARITY = 3'd3;
    localparam logic [2:0] c_RX_STOP   = 3'd4;
    localparam logic [2:0] c_RX_WAIT   = 3'd5;

    logic [2:0]           r_tx_state;
    logic [c_CW-1:0]      r_tx_cnt;
    logic [3:0]           r_tx_idx;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 r_tx_line;
    logic                 r_tx_busy;

    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic [2:0]           r_rx_state;
    logic [c_CW-1:0]      r_rx_cnt;
    logic [3:0]           r_rx_idx;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par_bit;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_rx_perr;
    logic                 r_rx_ferr;

    // Transmitter: one bit period per state step, counter restarts on every bit
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tx_state <= c_TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_line  <= 1'b1;
            r_tx_busy  <= 1'b0;
        end else if (r_tx_state == c_TX_IDLE) begin
            if (tx_start) begin
                r_tx_shift <= tx_data;
                r_tx_par   <= (^tx_data) ^ c_ODD;
                r_tx_busy  <= 1'b1;
                r_tx_line  <= 1'b0;
                r_tx_cnt   <= '0;
                r_tx_state <= c_TX_START;
            end
        end else if (r_tx_cnt != c_BIT_LAST) begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
        end else begin
            r_tx_cnt <= '0;
            case (r_tx_state)
                c_TX_START: begin
                    r_tx_line  <= r_tx_shift[0];
                    r_tx_shift <= r_tx_shift >> 1;
                    r_tx_idx   <= '0;
                    r_tx_state <= c_TX_DATA;
                end
                c_TX_DATA: begin
                    if (r_tx_idx != c_DATA_LAST) begin
                        r_tx_line  <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_idx   <= r_tx_idx + 1'b1;
                    end else if (c_HAS_PAR) begin
                        r_tx_line  <= r_tx_par;
                        r_tx_state <= c_TX_PARITY;
                    end else begin
                        r_tx_line  <= 1'b1;
                        r_tx_idx   <= '0;
                        r_tx_state <= c_TX_STOP;
                    end
                end
                c_TX_PARITY: begin
                    r_tx_line  <= 1'b1;
                    r_tx_idx   <= '0;
                    r_tx_state <= c_TX_STOP;
                end
                c_TX_STOP: begin
                    if (r_tx_idx != c_STOP_LAST) begin
                        r_tx_idx <= r_tx_idx + 1'b1;
                    end else begin
                        r_tx_busy  <= 1'b0;
                        r_tx_state <= c_TX_IDLE;
                    end
                end
                default: r_tx_state <= c_TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Receiver: after the start midpoint every sample lands one bit period later
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rx_state   <= c_RX_IDLE;
            r_rx_cnt     <= '0;
            r_rx_idx     <= '0;
            r_rx_shift   <= '0;
            r_rx_par_bit <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_perr    <= 1'b0;
            r_rx_ferr    <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_rx_state)
                c_RX_IDLE: begin
                    if (!r_rx_sync) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= c_RX_START;
                    end
                end
                c_RX_START: begin
                    if (r_rx_cnt != c_HALF_LAST) begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end else begin
                        r_rx_cnt   <= '0;
                        r_rx_idx   <= '0;
                        r_rx_state <= r_rx_sync ? c_RX_IDLE : c_RX_DATA;
                    end
                end
                c_RX_DATA: begin
                    if (r_rx_cnt != c_BIT_LAST) begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end else begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_idx != c_DATA_LAST) begin
                            r_rx_idx <= r_rx_idx + 1'b1;
                        end else begin
                            r_rx_state <= c_HAS_PAR ? c_RX_PARITY : c_RX_STOP;
                        end
                    end
                end
                c_RX_PARITY: begin
                    if (r_rx_cnt != c_BIT_LAST) begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end else begin
                        r_rx_cnt     <= '0;
                        r_rx_par_bit <= r_rx_sync;
                        r_rx_state   <= c_RX_STOP;
                    end
                end
                c_RX_STOP: begin
                    if (r_rx_cnt != c_BIT_LAST) begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end else begin
                        r_rx_cnt   <= '0;
                        r_rx_valid <= 1'b1;
                        r_rx_data  <= r_rx_shift;
                        r_rx_perr  <= c_HAS_PAR && (((^r_rx_shift) ^ r_rx_par_bit) != c_ODD);
                        r_rx_ferr  <= !r_rx_sync;
                        r_rx_state <= r_rx_sync ? c_RX_IDLE : c_RX_WAIT;
                    end
                end
                c_RX_WAIT: begin
                    if (r_rx_sync) begin
                        r_rx_state <= c_RX_IDLE;
                    end
                end
                default: r_rx_state <= c_RX_IDLE;
            endcase
        end
    end

    assign TX            = r_tx_line;
    assign tx_busy       = r_tx_busy;
    assign rx_data       = r_rx_data;
    assign rx_valid      = r_rx_valid;
    assign rx_parity_err = r_rx_perr;
    assign rx_frame_err  = r_rx_ferr;

endmodule
`default_nettype wire

// File: tb/tb_uart_transceiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_transceiver
//  Brief    : Self-checking bench: 8N1 and 8E1 instances against a bit-list
//             frame model, table-driven receive vectors and corner sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_transceiver;
    localparam int CLK_HZ = 16000;
    localparam int BAUD   = 100;
    localparam int OS     = 16;
    localparam int BIT    = 160;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] tx_data0, rx_data0, tx_data2, rx_data2;
    logic tx_start0, tx_busy0, tx0, rx_valid0, perr0, ferr0;
    logic tx_start2, tx_busy2, tx2, rx_valid2, perr2, ferr2;
    logic loop2, rx_drv, rx2;
    assign rx2 = loop2 ? tx2 : rx_drv;

    uart_transceiver #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                       .STOP_BITS(1), .OVERSAMPLE(OS)) dut0 (
        .CLK(clk), .RST(rst), .tx_data(tx_data0), .tx_start(tx_start0),
        .tx_busy(tx_busy0), .TX(tx0), .RX(tx0), .rx_data(rx_data0),
        .rx_valid(rx_valid0), .rx_parity_err(perr0), .rx_frame_err(ferr0));

    uart_transceiver #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2),
                       .STOP_BITS(1), .OVERSAMPLE(OS)) dut2 (
        .CLK(clk), .RST(rst), .tx_data(tx_data2), .tx_start(tx_start2),
        .tx_busy(tx_busy2), .TX(tx2), .RX(rx2), .rx_data(rx_data2),
        .rx_valid(rx_valid2), .rx_parity_err(perr2), .rx_frame_err(ferr2));

    int checks = 0;
    int errors = 0;
    int vcnt0 = 0;
    int vcnt2 = 0;
    always @(posedge clk) begin
        if (rx_valid0) vcnt0 <= vcnt0 + 1;
        if (rx_valid2) vcnt2 <= vcnt2 + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame: list of line levels, one entry per bit period
    bit exp_bits[$];
    logic par_sample;

    function automatic bit par_bit(input logic [7:0] d, input int par);
        int ones = $countones(d);
        if (par == 1) return bit'((ones % 2) == 0);
        return bit'((ones % 2) == 1);
    endfunction

    task automatic make_frame(input logic [7:0] d, input int par, input bit flip);
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
        if (par != 0) exp_bits.push_back(par_bit(d, par) ^ flip);
        exp_bits.push_back(1'b1);
    endtask

    task automatic send_tx(input int which, input logic [7:0] d, input int retry_at);
        int par = (which == 0) ? 0 : 2;
        int bad = 0;
        int busy_len = 0;
        int nbits;
        logic act_tx, act_busy, exp_tx;
        make_frame(d, par, 1'b0);
        nbits = exp_bits.size();
        if (which == 0) begin tx_data0 = d; tx_start0 = 1'b1; end
        else begin tx_data2 = d; tx_start2 = 1'b1; end
        @(negedge clk);
        tx_start0 = 1'b0;
        tx_start2 = 1'b0;
        tx_data0  = 8'($urandom);
        tx_data2  = 8'($urandom);
        for (int t = 0; t < nbits * BIT + 40; t++) begin
            act_tx   = (which == 0) ? tx0 : tx2;
            act_busy = (which == 0) ? tx_busy0 : tx_busy2;
            exp_tx   = (t < nbits * BIT) ? exp_bits[t / BIT] : 1'b1;
            if (act_tx !== exp_tx) bad++;
            if (act_busy === 1'b1) busy_len++;
            if (t == 9 * BIT + BIT / 2) par_sample = act_tx;
            if (t == retry_at) begin
                if (which == 0) begin tx_data0 = ~d; tx_start0 = 1'b1; end
                else begin tx_data2 = ~d; tx_start2 = 1'b1; end
            end
            if (t == retry_at + 1) begin
                tx_start0 = 1'b0;
                tx_start2 = 1'b0;
            end
            @(negedge clk);
        end
        check("tx_wave_bad_cycles", bad, 0);
        check("tx_busy_cycles", busy_len, nbits * BIT);
    endtask

    task automatic drive_rx(input logic [7:0] d, input bit flip, input int stop_low);
        make_frame(d, 2, flip);
        for (int b = 0; b < exp_bits.size() - 1; b++) begin
            rx_drv = exp_bits[b];
            repeat (BIT) @(negedge clk);
        end
        if (stop_low > 0) begin
            rx_drv = 1'b0;
            repeat (stop_low) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (BIT + 40) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         flip;
        int         stop_low;
        logic [7:0] exp_data;
        bit         exp_perr;
        bit         exp_ferr;
    } rx_vec_t;

    rx_vec_t vecs[6];

    initial begin
        int v;
        logic [7:0] d;
        bit f;
        logic [7:0] held;

        vecs[0] = '{8'h37, 1'b0, 0,   8'h37, 1'b0, 1'b0};
        vecs[1] = '{8'h37, 1'b1, 0,   8'h37, 1'b1, 1'b0};
        vecs[2] = '{8'hC4, 1'b0, 500, 8'hC4, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 1'b0, 0,   8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 0,   8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'h5A, 1'b0, 0,   8'h5A, 1'b0, 1'b0};

        loop2 = 1'b0;
        rx_drv = 1'b1;
        tx_start0 = 1'b0; tx_start2 = 1'b0;
        tx_data0 = 8'h00; tx_data2 = 8'h00;

        // Reset held under random stimulus
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tx_start0 = 1'($urandom); tx_start2 = 1'($urandom);
            tx_data0 = 8'($urandom); tx_data2 = 8'($urandom);
            rx_drv = 1'($urandom);
        end
        @(negedge clk);
        check("rst_tx0", tx0, 1);
        check("rst_busy0", tx_busy0, 0);
        check("rst_valid0", rx_valid0, 0);
        check("rst_data0", rx_data0, 0);
        check("rst_perr0", perr0, 0);
        check("rst_ferr0", ferr0, 0);
        check("rst_tx2", tx2, 1);
        check("rst_busy2", tx_busy2, 0);
        check("rst_valid2", rx_valid2, 0);
        check("rst_data2", rx_data2, 0);
        check("rst_perr2", perr2, 0);
        check("rst_ferr2", ferr2, 0);
        tx_start0 = 1'b0; tx_start2 = 1'b0; rx_drv = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // 8N1: 0xA5 with an ignored retry, then random words, all looped back
        v = vcnt0;
        send_tx(0, 8'hA5, 300);
        check("n1_rx_pulses", vcnt0 - v, 1);
        check("n1_rx_data", rx_data0, 8'hA5);
        check("n1_perr", perr0, 0);
        for (int k = 0; k < 3; k++) begin
            d = 8'($urandom);
            v = vcnt0;
            send_tx(0, d, (k == 1) ? 800 : -1);
            check("n1_rand_pulses", vcnt0 - v, 1);
            check("n1_rand_data", rx_data0, d);
            check("n1_rand_ferr", ferr0, 0);
        end

        // 8E1 loopback
        loop2 = 1'b1;
        v = vcnt2;
        send_tx(2, 8'h37, -1);
        check("e1_parity_bit", par_sample, 1);
        check("e1_rx_pulses", vcnt2 - v, 1);
        check("e1_rx_data", rx_data2, 8'h37);
        check("e1_perr", perr2, 0);
        check("e1_ferr", ferr2, 0);
        for (int k = 0; k < 3; k++) begin
            d = 8'($urandom);
            v = vcnt2;
            send_tx(2, d, -1);
            check("e1_rand_parity_bit", par_sample, par_bit(d, 2));
            check("e1_rand_pulses", vcnt2 - v, 1);
            check("e1_rand_data", rx_data2, d);
            check("e1_rand_perr", perr2, 0);
        end
        loop2 = 1'b0;
        repeat (20) @(negedge clk);

        // Bench-driven receive vectors, including parity flip and long break
        for (int i = 0; i < 6; i++) begin
            v = vcnt2;
            drive_rx(vecs[i].data, vecs[i].flip, vecs[i].stop_low);
            check("vec_pulses", vcnt2 - v, 1);
            check("vec_data", rx_data2, vecs[i].exp_data);
            check("vec_perr", perr2, vecs[i].exp_perr);
            check("vec_ferr", ferr2, vecs[i].exp_ferr);
        end
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom);
            f = 1'($urandom);
            v = vcnt2;
            drive_rx(d, f, 0);
            check("rand_rx_pulses", vcnt2 - v, 1);
            check("rand_rx_data", rx_data2, d);
            check("rand_rx_perr", perr2, f);
            check("rand_rx_ferr", ferr2, 0);
        end

        // 40-cycle glitch must not produce a frame; a real frame follows
        held = rx_data2;
        v = vcnt2;
        rx_drv = 1'b0;
        repeat (40) @(negedge clk);
        rx_drv = 1'b1;
        repeat (400) @(negedge clk);
        check("glitch_pulses", vcnt2 - v, 0);
        check("glitch_data_held", rx_data2, held);
        drive_rx(8'h81, 1'b0, 0);
        check("post_glitch_pulses", vcnt2 - v, 1);
        check("post_glitch_data", rx_data2, 8'h81);

        // Reset 500 cycles into a TX frame
        v = vcnt0;
        tx_data0 = 8'h00;
        tx_start0 = 1'b1;
        @(negedge clk);
        tx_start0 = 1'b0;
        repeat (500) @(negedge clk);
        check("pre_rst_tx_low", tx0, 0);
        check("pre_rst_busy", tx_busy0, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_tx", tx0, 1);
        check("mid_rst_busy", tx_busy0, 0);
        repeat (3) @(negedge clk);
        check("mid_rst_rx_data", rx_data0, 0);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check("mid_rst_no_pulse", vcnt0 - v, 0);
        send_tx(0, 8'h96, -1);
        check("post_rst_pulses", vcnt0 - v, 1);
        check("post_rst_data", rx_data0, 8'h96);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
